// File: rtl/ground_scroll_ctrl.sv
// ground_scroll_ctrl: run/crash game flow, scroll-step timebase, scroll offset and speed ramp for the ground renderer
// Ports: clk, rst (async, active-high), start_btn, collision in; game_status, crashed, ground_position[5:0],
// speed[3:0], step_pulse, distance[15:0] out. Optional GROUND_SCROLL_PAUSE_EN adds pause_btn input.
module ground_scroll_ctrl #(
  parameter int PERIOD      = 40,
  parameter int STEP_CYCLES = 16384,
  parameter int SPEED_INIT  = 4,
  parameter int SPEED_MAX   = 12,
  parameter int RAMP_STEPS  = 512,
  parameter int CRASH_HOLD  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_btn,
  input  logic        collision,
`ifdef GROUND_SCROLL_PAUSE_EN
  input  logic        pause_btn,
`endif
  output logic        game_status,
  output logic        crashed,
  output logic [5:0]  ground_position,
  output logic [3:0]  speed,
  output logic        step_pulse,
  output logic [15:0] distance
);
  localparam int DW = STEP_CYCLES > 1 ? $clog2(STEP_CYCLES) : 1;
  localparam int RW = RAMP_STEPS > 1 ? $clog2(RAMP_STEPS) : 1;
  localparam int HW = $clog2(CRASH_HOLD + 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(STEP_CYCLES - 1);
  localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_STEPS - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(CRASH_HOLD);
  localparam logic [3:0]    SPD_INIT  = 4'(SPEED_INIT);
  localparam logic [3:0]    SPD_MAX   = 4'(SPEED_MAX);
  typedef enum logic [1:0] {IDLE, RUN, CRASH} state_t;
  state_t        state;
  logic          start_q;
  logic [DW-1:0] div;
  logic [RW-1:0] ramp;
  logic [HW-1:0] hold;
  logic          start_ev, tick, go, paused, paused_nx;
  logic [6:0]    sum;
  logic [5:0]    next_pos;
  assign start_ev = start_btn & ~start_q;
  assign tick     = div == DIV_LAST;
  assign go       = start_ev & (state == IDLE | (state == CRASH & hold == HOLD_MAX));
  // 7-bit sum so the wrap compare sees the carry; one subtract suffices since speed < PERIOD
  assign sum      = {1'b0, ground_position} + {3'b000, speed};
  assign next_pos = sum >= 7'(PERIOD) ? 6'(sum - 7'(PERIOD)) : sum[5:0];
`ifdef GROUND_SCROLL_PAUSE_EN
  logic pause_q;
  // a collision while running leaves RUN, which also drops the pause
  assign paused_nx = (state == RUN & ~(collision & ~paused)) ? paused ^ (pause_btn & ~pause_q) : 1'b0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pause_q <= 1'b0;
      paused  <= 1'b0;
    end else begin
      pause_q <= pause_btn;
      paused  <= paused_nx;
    end
`else
  assign paused    = 1'b0;
  assign paused_nx = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state           <= IDLE;
      start_q         <= 1'b0;
      div             <= '0;
      ramp            <= '0;
      hold            <= '0;
      game_status     <= 1'b0;
      crashed         <= 1'b0;
      ground_position <= '0;
      speed           <= SPD_INIT;
      step_pulse      <= 1'b0;
      distance        <= '0;
    end else begin
      start_q    <= start_btn;
      step_pulse <= 1'b0;
      if (go) begin
        state           <= RUN;
        game_status     <= 1'b1;
        crashed         <= 1'b0;
        ground_position <= '0;
        distance        <= '0;
        speed           <= SPD_INIT;
        div             <= '0;
        ramp            <= '0;
      end else if (state == RUN) begin
        if (!paused) begin
          div <= tick ? '0 : div + 1'b1;
          if (collision) begin
            state       <= CRASH;
            game_status <= 1'b0;
            crashed     <= 1'b1;
            hold        <= '0;
          end else begin
            game_status <= ~paused_nx;
            if (tick) begin
              step_pulse      <= 1'b1;
              ground_position <= next_pos;
              distance        <= distance + {15'd0, distance != 16'hFFFF};
              ramp            <= ramp == RAMP_LAST ? '0 : ramp + 1'b1;
              if (ramp == RAMP_LAST && speed != SPD_MAX) speed <= speed + 1'b1;
            end
          end
        end else game_status <= ~paused_nx;
      end else if (state == CRASH) begin
        div <= tick ? '0 : div + 1'b1;
        if (tick && hold != HOLD_MAX) hold <= hold + 1'b1;
      end
    end
endmodule

// File: tb/tb_ground_scroll_ctrl.sv
// tb_ground_scroll_ctrl: randomized bench for ground_scroll_ctrl against a step-count based reference model
module tb_ground_scroll_ctrl;
  localparam int PERIOD = 40, SC = 4, SI = 4, SM = 12, RS = 3, CH = 2;
  logic clk = 0, rst = 0, start_btn = 0, collision = 0;
  logic game_status, crashed, step_pulse;
  logic [5:0] ground_position;
  logic [3:0] speed;
  logic [15:0] distance;
  int checks = 0, failures = 0;
  int m_state, m_phase, m_steps, m_pos, m_ct;
  bit m_prev, m_pulse;
  int lit_pos [10] = '{4, 8, 12, 17, 22, 27, 33, 39, 5, 12};

  ground_scroll_ctrl #(.STEP_CYCLES(SC), .RAMP_STEPS(RS), .CRASH_HOLD(CH)) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .collision(collision),
    .game_status(game_status), .crashed(crashed), .ground_position(ground_position),
    .speed(speed), .step_pulse(step_pulse), .distance(distance));

  always #5 clk = ~clk;

  function automatic int m_speed();
    return (SI + m_steps / RS > SM) ? SM : SI + m_steps / RS;
  endfunction

  function automatic void chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", n, act, exp, $time);
    end
  endfunction

  // reference: state 0 idle, 1 run, 2 crash; speed and distance derive from steps taken this run
  always @(posedge clk or posedge rst) begin
    bit ev, tk;
    if (rst) begin
      m_state = 0; m_phase = 0; m_steps = 0; m_pos = 0; m_ct = 0; m_prev = 0; m_pulse = 0;
    end else begin
      ev = start_btn && !m_prev;
      m_prev = start_btn;
      m_pulse = 0;
      tk = m_phase == SC - 1;
      if (ev && (m_state == 0 || (m_state == 2 && m_ct >= CH))) begin
        m_state = 1; m_phase = 0; m_steps = 0; m_pos = 0;
      end else if (m_state == 1) begin
        m_phase = (m_phase + 1) % SC;
        if (collision) begin
          m_state = 2; m_ct = 0;
        end else if (tk) begin
          m_pos = (m_pos + m_speed()) % PERIOD;
          m_steps++;
          m_pulse = 1;
        end
      end else if (m_state == 2) begin
        m_phase = (m_phase + 1) % SC;
        if (tk && m_ct < CH) m_ct++;
      end
    end
  end

  always @(negedge clk) if (!rst) begin
    chk("game_status", game_status, m_state == 1);
    chk("crashed", crashed, m_state == 2);
    chk("ground_position", ground_position, m_pos);
    chk("speed", speed, m_speed());
    chk("distance", distance, m_steps > 65535 ? 65535 : m_steps);
    chk("step_pulse", step_pulse, m_pulse);
  end

  task automatic wait_pulse(string n);
    int k = 0;
    do begin @(negedge clk); k++; end while (!step_pulse && k < 40);
    checks++;
    if (!step_pulse) begin failures++; $display("FAIL %s timeout actual=no_pulse expected=pulse", n); end
  endtask

  task automatic wait_pre_tick();
    int k = 0;
    while (!(m_state == 1 && m_phase == SC - 1) && k < 40) begin @(negedge clk); k++; end
    checks++;
    if (k >= 40) begin failures++; $display("FAIL pre_tick timeout actual=none expected=tick"); end
  endtask

  initial begin
    #1 rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    chk("rst_pos", ground_position, 0);
    chk("rst_speed", speed, 4);
    chk("rst_status", game_status, 0);
    repeat (100) @(negedge clk);
    chk("idle_pos", ground_position, 0);
    chk("idle_speed", speed, 4);
    start_btn = 1;
    @(negedge clk);
    chk("start_latency", game_status, 1);
    for (int i = 0; i < 10; i++) begin
      wait_pulse("step");
      chk($sformatf("step%0d_pos", i + 1), ground_position, lit_pos[i]);
      if (i == 2) chk("speed_after3", speed, 5);
      if (i == 5) chk("speed_after6", speed, 6);
    end
    start_btn = 0;
    chk("run_distance", distance, 10);
    chk("run_speed", speed, 7);
    wait_pre_tick();
    collision = 1;
    @(negedge clk);
    collision = 0;
    chk("crash_flag", crashed, 1);
    chk("crash_no_pulse", step_pulse, 0);
    chk("crash_pos", ground_position, 12);
    chk("crash_dist", distance, 10);
    start_btn = 1;
    @(negedge clk);
    start_btn = 0;
    @(negedge clk);
    chk("early_start_ignored", crashed, 1);
    repeat (12) @(negedge clk);
    start_btn = 1;
    @(negedge clk);
    start_btn = 0;
    chk("restart_status", game_status, 1);
    chk("restart_pos", ground_position, 0);
    chk("restart_speed", speed, 4);
    chk("restart_dist", distance, 0);
    wait_pulse("pre_reset_step");
    chk("pre_reset_pos", ground_position, 4);
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("async_pos", ground_position, 0);
    chk("async_status", game_status, 0);
    chk("async_speed", speed, 4);
    chk("async_dist", distance, 0);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start_btn = $urandom % 4 == 0;
      collision = i < 1500 ? $urandom % 40 == 0 : $urandom % 300 == 0;
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
